// File: rtl/data_bus_timer.sv
// Memory-mapped 32-bit timer/counter slave for the OpenMIPS data bus.
// Provides a prescaled up-counter, compare match with optional auto-reload, and a level interrupt.
module data_bus_timer #(
    parameter int          PRESCALE_W  = 16,
    parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        int_o
);

    localparam logic [2:0] A_CTRL     = 3'd0;
    localparam logic [2:0] A_COUNT    = 3'd1;
    localparam logic [2:0] A_COMPARE  = 3'd2;
    localparam logic [2:0] A_STATUS   = 3'd3;
    localparam logic [2:0] A_PRESCALE = 3'd4;

    logic [2:0]            ctrl, ctrl_nx;
    logic [31:0]           count, count_nx, count_tick;
    logic [31:0]           compare, compare_nx;
    logic                  match, match_nx;
    logic [PRESCALE_W-1:0] prescale, prescale_nx;
    logic [PRESCALE_W-1:0] pcnt, pcnt_nx;
    logic                  wr, tick, hit;
    logic [2:0]            idx;
    logic                  unused_addr;

    assign unused_addr = ^{addr[31:5], addr[1:0]};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        merge_bytes = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merge_bytes[i*8 +: 8] = new_v[i*8 +: 8];
        end
    endfunction

    // Bus writes are layered on top of the tick-updated values so that selected bytes win.
    always_comb begin
        wr   = ce & we;
        idx  = addr[4:2];
        tick = ctrl[0] && (pcnt == prescale);
        hit  = tick && (count == compare);

        if (hit && ctrl[1])
            count_tick = '0;
        else if (tick)
            count_tick = count + 32'd1;
        else
            count_tick = count;

        ctrl_nx     = ctrl;
        count_nx    = count_tick;
        compare_nx  = compare;
        match_nx    = match;
        prescale_nx = prescale;

        if (wr) begin
            case (idx)
                A_CTRL:     if (sel[0]) ctrl_nx = data_i[2:0];
                A_COUNT:    count_nx   = merge_bytes(count_tick, data_i, sel);
                A_COMPARE:  compare_nx = merge_bytes(compare, data_i, sel);
                A_STATUS:   if (sel[0] && data_i[0]) match_nx = 1'b0;
                A_PRESCALE: begin
                    for (int i = 0; i < PRESCALE_W; i++) begin
                        if (sel[i/8]) prescale_nx[i] = data_i[i];
                    end
                end
                default: ;
            endcase
        end

        // A new match overrides a same-edge clear.
        if (hit) match_nx = 1'b1;

        if (!ctrl[0] || !ctrl_nx[0] || tick)
            pcnt_nx = '0;
        else
            pcnt_nx = pcnt + PRESCALE_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl     <= '0;
            count    <= '0;
            compare  <= COMPARE_RST;
            match    <= 1'b0;
            prescale <= '0;
            pcnt     <= '0;
        end else begin
            ctrl     <= ctrl_nx;
            count    <= count_nx;
            compare  <= compare_nx;
            match    <= match_nx;
            prescale <= prescale_nx;
            pcnt     <= pcnt_nx;
        end
    end

    always_comb begin
        data_o = '0;
        if (ce && !we) begin
            case (idx)
                A_CTRL:     data_o = {29'd0, ctrl};
                A_COUNT:    data_o = count;
                A_COMPARE:  data_o = compare;
                A_STATUS:   data_o = {31'd0, match};
                A_PRESCALE: data_o = 32'(prescale);
                default:    data_o = '0;
            endcase
        end
    end

    assign int_o = match & ctrl[2];

endmodule

// File: tb/tb_data_bus_timer.sv
// Directed self-checking bench for data_bus_timer with hand-computed expected values.
module tb_data_bus_timer;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        int_o;

    int          check_count;
    int          error_count;
    logic [31:0] rd;
    logic [31:0] exp_rst [8];

    data_bus_timer #(
        .PRESCALE_W  (16),
        .COMPARE_RST (32'hFFFF_FFFF)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .we     (we),
        .addr   (addr),
        .sel    (sel),
        .data_i (data_i),
        .data_o (data_o),
        .int_o  (int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // One bus write, committed on the next rising edge; returns at the following falling edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        addr   = a;
        data_i = d;
        sel    = s;
        ce     = 1'b1;
        we     = 1'b1;
        @(negedge clk);
        ce     = 1'b0;
        we     = 1'b0;
        sel    = 4'h0;
    endtask

    task automatic readRegister(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        sel  = 4'h0;
        ce   = 1'b1;
        we   = 1'b0;
        #1;
        d    = data_o;
        ce   = 1'b0;
    endtask

    initial begin
        check_count = 0;
        error_count = 0;
        exp_rst = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        rst    = 1'b1;
        ce     = 1'b0;
        we     = 1'b0;
        addr   = '0;
        sel    = '0;
        data_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state of every offset.
        checkOutput("rst_int", 32'(int_o), 32'h0);
        checkOutput("idle_data", data_o, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            readRegister(32'(i * 4), rd);
            checkOutput($sformatf("rst_reg%0d", i), rd, exp_rst[i]);
        end

        // Prescale 3, compare 5, enable with reload and interrupt.
        applyStimulus(32'h10, 32'h3, 4'hF);
        applyStimulus(32'h08, 32'h5, 4'hF);
        applyStimulus(32'h00, 32'h7, 4'hF);
        repeat (3) @(negedge clk);
        readRegister(32'h04, rd); checkOutput("pre_first_tick", rd, 32'h0);
        @(negedge clk);
        readRegister(32'h04, rd); checkOutput("first_tick", rd, 32'h1);
        repeat (15) @(negedge clk);
        readRegister(32'h04, rd); checkOutput("count4", rd, 32'h4);
        @(negedge clk);
        readRegister(32'h04, rd); checkOutput("count5", rd, 32'h5);
        readRegister(32'h0C, rd); checkOutput("no_match_yet", rd, 32'h0);
        checkOutput("int_low", 32'(int_o), 32'h0);
        repeat (4) @(negedge clk);
        readRegister(32'h04, rd); checkOutput("reload", rd, 32'h0);
        readRegister(32'h0C, rd); checkOutput("match_set", rd, 32'h1);
        checkOutput("int_high", 32'(int_o), 32'h1);
        applyStimulus(32'h0C, 32'h0, 4'hF);
        checkOutput("w0_no_clear", 32'(int_o), 32'h1);
        applyStimulus(32'h0C, 32'h1, 4'hF);
        checkOutput("w1c_int", 32'(int_o), 32'h0);
        readRegister(32'h0C, rd); checkOutput("w1c_status", rd, 32'h0);

        // Wrap past all-ones without reload and without a match.
        applyStimulus(32'h00, 32'h0, 4'hF);
        applyStimulus(32'h10, 32'h0, 4'hF);
        applyStimulus(32'h08, 32'h10, 4'hF);
        applyStimulus(32'h04, 32'hFFFF_FFFE, 4'hF);
        applyStimulus(32'h00, 32'h1, 4'hF);
        readRegister(32'h04, rd); checkOutput("en_latency", rd, 32'hFFFF_FFFE);
        @(negedge clk);
        readRegister(32'h04, rd); checkOutput("wrap_ff", rd, 32'hFFFF_FFFF);
        @(negedge clk);
        readRegister(32'h04, rd); checkOutput("wrap_0", rd, 32'h0);
        @(negedge clk);
        readRegister(32'h04, rd); checkOutput("wrap_1", rd, 32'h1);
        readRegister(32'h0C, rd); checkOutput("wrap_nomatch", rd, 32'h0);

        // Byte lanes, no-op writes, masked and reserved registers.
        applyStimulus(32'h00, 32'h0, 4'hF);
        applyStimulus(32'h08, 32'hFFFF_FFFF, 4'hF);
        applyStimulus(32'h08, 32'hAABB_CCDD, 4'h4);
        readRegister(32'h08, rd); checkOutput("lane2", rd, 32'hFFBB_FFFF);
        applyStimulus(32'h08, 32'h0, 4'h0);
        readRegister(32'h08, rd); checkOutput("sel_none", rd, 32'hFFBB_FFFF);
        applyStimulus(32'h00, 32'hFFFF_FFFA, 4'hF);
        readRegister(32'h00, rd); checkOutput("ctrl_mask", rd, 32'h2);
        applyStimulus(32'h10, 32'hABCD_1234, 4'hF);
        readRegister(32'h10, rd); checkOutput("presc_mask", rd, 32'h1234);
        applyStimulus(32'h14, 32'h1234_5678, 4'hF);
        readRegister(32'h14, rd); checkOutput("reserved", rd, 32'h0);
        applyStimulus(32'h00, 32'h0, 4'hF);
        applyStimulus(32'h10, 32'h0, 4'hF);

        // Same-edge collisions with a tick every cycle.
        applyStimulus(32'h08, 32'hFFFF_FFFF, 4'hF);
        applyStimulus(32'h04, 32'h0, 4'hF);
        applyStimulus(32'h00, 32'h1, 4'hF);
        applyStimulus(32'h04, 32'h100, 4'hF);
        readRegister(32'h04, rd); checkOutput("wr_on_tick", rd, 32'h100);
        @(negedge clk);
        readRegister(32'h04, rd); checkOutput("after_wr", rd, 32'h101);
        applyStimulus(32'h04, 32'h80, 4'h1);
        readRegister(32'h04, rd); checkOutput("partial_tick", rd, 32'h180);
        applyStimulus(32'h08, 32'h183, 4'hF);
        repeat (2) @(negedge clk);
        applyStimulus(32'h0C, 32'h1, 4'hF);
        readRegister(32'h0C, rd); checkOutput("set_wins", rd, 32'h1);
        readRegister(32'h04, rd); checkOutput("no_reload", rd, 32'h184);
        applyStimulus(32'h0C, 32'h1, 4'hF);
        readRegister(32'h0C, rd); checkOutput("late_clear", rd, 32'h0);

        // Asynchronous reset between edges.
        applyStimulus(32'h00, 32'h0, 4'hF);
        applyStimulus(32'h08, 32'h3, 4'hF);
        applyStimulus(32'h04, 32'h3, 4'hF);
        applyStimulus(32'h00, 32'h7, 4'hF);
        @(negedge clk);
        checkOutput("pre_rst_int", 32'(int_o), 32'h1);
        #2;
        rst = 1'b1;
        #0.5;
        checkOutput("arst_int", 32'(int_o), 32'h0);
        readRegister(32'h04, rd); checkOutput("arst_count", rd, 32'h0);
        readRegister(32'h00, rd); checkOutput("arst_ctrl", rd, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        readRegister(32'h04, rd); checkOutput("post_rst_hold", rd, 32'h0);
        readRegister(32'h08, rd); checkOutput("post_rst_cmp", rd, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/data_bus_timer.md
Name: data_bus_timer

Overview:
- Memory-mapped timer/counter slave on the OpenMIPS data bus; sits downstream of the core's ram_* port, alongside data_ram, behind an external address decoder that drives ce.
- 32-bit up-counter with programmable prescaler, compare-match flag, optional auto-reload and a level interrupt output.
- Bus protocol matches data_ram:
  - combinational read;
  - write on rising clk edge with byte selects;
  - big-endian lane mapping.

Parameters:
- PRESCALE_W, 16, width of the PRESCALE register and of the internal prescale counter.
- COMPARE_RST, 32'hFFFF_FFFF, reset value of the COMPARE register.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- ce  input  1  slave select from external decoder
- we  input  1  1 = write, 0 = read
- addr  input  32  byte address; only addr[4:2] decoded
- sel  input  4  byte enables; sel[3] -> data_i[31:24] … sel[0] -> data_i[7:0]
- data_i  input  32  write data
- data_o  output  32  read data
- int_o  output  1  timer interrupt, level, active-high

Behaviour:
- Reset: one clock; rst asynchronous and active-high, asserting immediately clears all state.
- Reset values:
  - CTRL = 0, COUNT = 0, COMPARE = COMPARE_RST, MATCH = 0, PRESCALE = 0;
  - prescale counter pcnt = 0;
  - data_o = 0, int_o = 0.
- Register map (addr[4:2]):
  - 0 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IE; other bits read 0.
  - 1 COUNT: R/W.
  - 2 COMPARE: R/W.
  - 3 STATUS: bit0 MATCH, read; write 1 to clear (W1C), written 0 has no effect.
  - 4 PRESCALE: R/W, low PRESCALE_W bits; upper bits read 0.
  - 5–7: read 0, writes ignored.
- Read path:
  - data_o = selected register when ce=1 and we=0, else 0.
  - Purely combinational; reflects register state before the current edge.
  - sel is ignored on reads.
- Write path:
  - On posedge clk with ce=1 and we=1, each byte lane with sel[i]=1 is updated.
  - Result visible on data_o from the next cycle.
  - sel=0000 write is a no-op.
- Tick generation:
  - While EN=1: pcnt increments each cycle; when pcnt == PRESCALE, tick=1 that cycle and pcnt <= 0.
  - PRESCALE=0 gives a tick every cycle; PRESCALE=N gives one tick per N+1 cycles.
  - EN=0: pcnt held at 0, no ticks.
  - A write that clears EN also zeroes pcnt on the same edge.
- Count on tick:
  - If COUNT == COMPARE: MATCH <= 1, and COUNT <= 0 if AUTO_RELOAD=1, else COUNT+1.
  - Otherwise COUNT <= COUNT+1.
  - 32'hFFFF_FFFF + 1 wraps to 0, with no flag unless COMPARE matched.
- int_o = MATCH & IE (registered sources, no combinational path from bus inputs).
- Simultaneous events:
  - Bus write to COUNT on a tick edge: written bytes take the bus value; unselected bytes take the tick-updated value.
  - The compare check uses the pre-edge COUNT.
  - W1C of MATCH on the same edge as a new match: MATCH stays 1 (set wins).
  - Write to COMPARE on a tick edge: the compare uses the old COMPARE.
  - Write to PRESCALE: the new value is used from the next cycle; pcnt is not reset.
- rst asserted mid-count: all state returns to reset values immediately; no tick occurs until EN is rewritten.

Test Plan:
1. Reset then read each offset 0x00–0x1C -> 0, 0, FFFF_FFFF, 0, 0, 0, 0, 0; int_o=0.
2. Write PRESCALE=3, COMPARE=5, CTRL=0x7 -> COUNT advances every 4 cycles; MATCH and int_o rise on the tick where COUNT was 5; COUNT then reads 0 (auto-reload); write STATUS=1 -> int_o falls next cycle.
3. CTRL=0x1 (no reload), COUNT=32'hFFFF_FFFE, COMPARE=0x10, PRESCALE=0 -> COUNT reads FFFF_FFFF, then 0, then 1; MATCH stays 0.
4. Byte-lane write sel=0100, data_i=0xAABBCCDD to COMPARE (reset FFFF_FFFF) -> COMPARE reads 0xFFBBFFFF.
5. Same-edge collisions, PRESCALE=0, EN=1:
   - Write COUNT=0x100 with sel=1111 on a tick edge -> next cycle reads 0x100, following cycle 0x101.
   - W1C of STATUS on the edge that sets MATCH -> MATCH remains 1.
6. Assert rst asynchronously mid-count (between edges) -> COUNT, CTRL and int_o go to 0 before the next edge; after release, COUNT holds 0 until EN is written.
